// File: rtl/life_board_ring.sv
// Circular X*Y-cell board store for the Life engine: streams one cell per shift,
// tracks rotation for cursor edits, runs clear/random fill sweeps, snapshots frames.
module life_board_ring #(
  parameter int          X     = 8,
  parameter int          Y     = 8,
  parameter int          LOG2X = 3,
  parameter int          LOG2Y = 3,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   cell_in,
  output logic                   cell_out,
  input  logic [2:0]             cmd,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [LOG2X-1:0]       cursor_x,
  input  logic [LOG2Y-1:0]       cursor_y,
  output logic [LOG2X+LOG2Y-1:0] pos,
  output logic                   frame_start,
  output logic                   fill_done,
  output logic [X*Y-1:0]         board_snap
);

  localparam int              N         = X * Y;
  localparam int              PW        = LOG2X + LOG2Y;
  localparam logic [PW-1:0]   LAST      = PW'(N - 1);
  localparam logic [15:0]     LFSR_MASK = 16'hB400;

  localparam logic [2:0] CMD_FLIP        = 3'd1;
  localparam logic [2:0] CMD_SET         = 3'd2;
  localparam logic [2:0] CMD_CLR         = 3'd3;
  localparam logic [2:0] CMD_CLEAR_ALL   = 3'd4;
  localparam logic [2:0] CMD_RANDOM_FILL = 3'd5;

  typedef enum logic {IDLE, FILL} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    data_q, data_d;
  logic [N-1:0]    snap_q, snap_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic [PW-1:0]   cnt_q, cnt_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic            random_q, random_d;
  logic            frame_start_q, frame_start_d;
  logic            fill_done_q, fill_done_d;
  logic            cmd_ready_q, cmd_ready_d;

  logic            shift;
  logic            shift_in;
  logic            edit_en;
  logic            in_range;
  logic [PW:0]     lin_idx;
  logic [PW:0]     diff;
  logic [PW-1:0]   phys;

  assign in_range = ({1'b0, cursor_x} < (LOG2X + 1)'(X)) &&
                    ({1'b0, cursor_y} < (LOG2Y + 1)'(Y));
  assign lin_idx  = (PW + 1)'(cursor_y) * (PW + 1)'(X) + (PW + 1)'(cursor_x);

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    snap_d        = snap_q;
    pos_d         = pos_q;
    cnt_d         = cnt_q;
    lfsr_d        = lfsr_q;
    random_d      = random_q;
    frame_start_d = 1'b0;
    fill_done_d   = 1'b0;
    shift         = 1'b0;
    shift_in      = 1'b0;
    edit_en       = 1'b0;
    diff          = '0;
    phys          = '0;

    case (state_q)
      IDLE: begin
        shift    = run;
        shift_in = cell_in;
        if (cmd_valid) begin
          case (cmd)
            CMD_FLIP, CMD_SET, CMD_CLR: edit_en = in_range;
            CMD_CLEAR_ALL, CMD_RANDOM_FILL: begin
              state_d  = FILL;
              random_d = (cmd == CMD_RANDOM_FILL);
              cnt_d    = LAST;
            end
            default: ;
          endcase
        end
      end
      FILL: begin
        shift    = 1'b1;
        shift_in = random_q & lfsr_q[0];
        if (random_q)
          lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
        if (cnt_q == '0) begin
          state_d     = IDLE;
          fill_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (shift) begin
      data_d = {shift_in, data_q[N-1:1]};
      pos_d  = (pos_q == LAST) ? '0 : pos_q + 1'b1;
    end

    // Edits target the cell's location after this cycle's rotation.
    diff = lin_idx - {1'b0, pos_d};
    if (diff[PW])
      diff = diff + (PW + 1)'(N);
    phys = diff[PW-1:0];

    if (edit_en) begin
      for (int k = 0; k < N; k++) begin
        if (PW'(k) == phys) begin
          case (cmd)
            CMD_FLIP: data_d[k] = ~data_d[k];
            CMD_SET:  data_d[k] = 1'b1;
            CMD_CLR:  data_d[k] = 1'b0;
            default:  ;
          endcase
        end
      end
    end

    if (shift && (pos_d == '0)) begin
      frame_start_d = 1'b1;
      snap_d        = data_d;
    end

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      data_q        <= '0;
      snap_q        <= '0;
      pos_q         <= '0;
      cnt_q         <= '0;
      lfsr_q        <= SEED;
      random_q      <= 1'b0;
      frame_start_q <= 1'b0;
      fill_done_q   <= 1'b0;
      cmd_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      snap_q        <= snap_d;
      pos_q         <= pos_d;
      cnt_q         <= cnt_d;
      lfsr_q        <= lfsr_d;
      random_q      <= random_d;
      frame_start_q <= frame_start_d;
      fill_done_q   <= fill_done_d;
      cmd_ready_q   <= cmd_ready_d;
    end
  end

  assign cell_out    = data_q[0];
  assign cmd_ready   = cmd_ready_q;
  assign pos         = pos_q;
  assign frame_start = frame_start_q;
  assign fill_done   = fill_done_q;
  assign board_snap  = snap_q;

endmodule

// File: tb/tb_life_board_ring.sv
// Directed bench for life_board_ring: an 8x8 instance and a 6x5 instance
// driven with hand-computed vectors and a behavioural Galois LFSR model.
`timescale 1ns/1ps
module tb_life_board_ring;

  localparam logic [2:0] CMD_NOP         = 3'd0;
  localparam logic [2:0] CMD_FLIP        = 3'd1;
  localparam logic [2:0] CMD_SET         = 3'd2;
  localparam logic [2:0] CMD_CLR         = 3'd3;
  localparam logic [2:0] CMD_CLEAR_ALL   = 3'd4;
  localparam logic [2:0] CMD_RANDOM_FILL = 3'd5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_run, a_cell_in, a_cell_out, a_cmd_valid, a_cmd_ready;
  logic [2:0]  a_cmd, a_cx, a_cy;
  logic [5:0]  a_pos;
  logic        a_frame_start, a_fill_done;
  logic [63:0] a_snap;

  logic        b_reset, b_run, b_cell_in, b_cell_out, b_cmd_valid, b_cmd_ready;
  logic [2:0]  b_cmd, b_cx, b_cy;
  logic [5:0]  b_pos;
  logic        b_frame_start, b_fill_done;
  logic [29:0] b_snap;

  life_board_ring #(.X(8), .Y(8), .LOG2X(3), .LOG2Y(3), .SEED(16'hACE1)) dut_a (
    .clk(clk), .reset(a_reset), .run(a_run), .cell_in(a_cell_in), .cell_out(a_cell_out),
    .cmd(a_cmd), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cursor_x(a_cx), .cursor_y(a_cy), .pos(a_pos), .frame_start(a_frame_start),
    .fill_done(a_fill_done), .board_snap(a_snap)
  );

  life_board_ring #(.X(6), .Y(5), .LOG2X(3), .LOG2Y(3), .SEED(16'hACE1)) dut_b (
    .clk(clk), .reset(b_reset), .run(b_run), .cell_in(b_cell_in), .cell_out(b_cell_out),
    .cmd(b_cmd), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cursor_x(b_cx), .cursor_y(b_cy), .pos(b_pos), .frame_start(b_frame_start),
    .fill_done(b_fill_done), .board_snap(b_snap)
  );

  int           checkCount = 0;
  int           passCount  = 0;
  int           rdyLow, fsCount, fdCount;
  logic         seen;
  logic [15:0]  modelLfsr;
  logic [127:0] randBits;

  // Count one comparison and report it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock on the 8x8 instance with the given run/cell_in and optional command.
  task automatic applyStimulus(input logic run, input logic cin, input logic valid,
                               input logic [2:0] c, input logic [2:0] x, input logic [2:0] y);
    a_run = run; a_cell_in = cin; a_cmd_valid = valid; a_cmd = c; a_cx = x; a_cy = y;
    tick();
    a_run = 1'b0; a_cmd_valid = 1'b0; a_cmd = CMD_NOP;
  endtask

  task automatic applyStimulusB(input logic run, input logic cin, input logic valid,
                                input logic [2:0] c, input logic [2:0] x, input logic [2:0] y);
    b_run = run; b_cell_in = cin; b_cmd_valid = valid; b_cmd = c; b_cx = x; b_cy = y;
    tick();
    b_run = 1'b0; b_cmd_valid = 1'b0; b_cmd = CMD_NOP;
  endtask

  // Recirculating rotation keeps the logical board intact and refreshes the snapshot.
  task automatic spinA(input int n);
    for (int k = 0; k < n; k++) begin
      a_run = 1'b1; a_cell_in = a_cell_out;
      tick();
    end
    a_run = 1'b0; a_cell_in = 1'b0;
  endtask

  task automatic spinB(input int n);
    for (int k = 0; k < n; k++) begin
      b_run = 1'b1; b_cell_in = b_cell_out;
      tick();
    end
    b_run = 1'b0; b_cell_in = 1'b0;
  endtask

  task automatic waitFillA(input string tag);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (a_fill_done) seen = 1'b1;
      else tick();
    end
    checkOutput(tag, 64'(seen), 64'd1);
  endtask

  task automatic waitFillB(input string tag);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (b_fill_done) seen = 1'b1;
      else tick();
    end
    checkOutput(tag, 64'(seen), 64'd1);
  endtask

  initial begin
    a_reset = 1'b0; a_run = 1'b0; a_cell_in = 1'b0; a_cmd_valid = 1'b0; a_cmd = CMD_NOP; a_cx = '0; a_cy = '0;
    b_reset = 1'b0; b_run = 1'b0; b_cell_in = 1'b0; b_cmd_valid = 1'b0; b_cmd = CMD_NOP; b_cx = '0; b_cy = '0;

    modelLfsr = 16'hACE1;
    for (int k = 0; k < 128; k++) begin
      randBits[k] = modelLfsr[0];
      modelLfsr   = (modelLfsr >> 1) ^ (modelLfsr[0] ? 16'hB400 : 16'h0000);
    end

    // Reset state
    repeat (2) tick();
    a_reset = 1'b1; b_reset = 1'b1;
    #1;
    checkOutput("reset pos", 64'(a_pos), 64'd0);
    checkOutput("reset snap", a_snap, 64'd0);
    checkOutput("reset ready", 64'(a_cmd_ready), 64'd1);
    checkOutput("reset cell_out", 64'(a_cell_out), 64'd0);
    tick();
    checkOutput("reset frame_start", 64'(a_frame_start), 64'd0);
    checkOutput("reset fill_done", 64'(a_fill_done), 64'd0);

    // Edits at (3,2) with pos 0 land on bit 19
    applyStimulus(1'b0, 1'b0, 1'b1, CMD_FLIP, 3'd3, 3'd2);
    spinA(64);
    checkOutput("flip on", a_snap, 64'h0000_0000_0008_0000);
    checkOutput("flip pos", 64'(a_pos), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, CMD_FLIP, 3'd3, 3'd2);
    spinA(64);
    checkOutput("flip off", a_snap, 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, CMD_SET, 3'd3, 3'd2);
    applyStimulus(1'b0, 1'b0, 1'b1, CMD_SET, 3'd3, 3'd2);
    spinA(64);
    checkOutput("set twice", a_snap, 64'h0000_0000_0008_0000);
    applyStimulus(1'b0, 1'b0, 1'b1, CMD_CLR, 3'd3, 3'd2);
    spinA(64);
    checkOutput("clr", a_snap, 64'd0);

    // SET (0,0) during a shift whose pos_next is 10 lands on physical bit 54
    repeat (9) applyStimulus(1'b1, 1'b0, 1'b0, CMD_NOP, 3'd0, 3'd0);
    checkOutput("pos before set", 64'(a_pos), 64'd9);
    applyStimulus(1'b1, 1'b0, 1'b1, CMD_SET, 3'd0, 3'd0);
    checkOutput("pos at set", 64'(a_pos), 64'd10);
    repeat (53) applyStimulus(1'b1, 1'b0, 1'b0, CMD_NOP, 3'd0, 3'd0);
    checkOutput("cell_out early", 64'(a_cell_out), 64'd0);
    checkOutput("pos 63", 64'(a_pos), 64'd63);
    applyStimulus(1'b1, 1'b0, 1'b0, CMD_NOP, 3'd0, 3'd0);
    checkOutput("cell_out at wrap", 64'(a_cell_out), 64'd1);
    checkOutput("frame_start at wrap", 64'(a_frame_start), 64'd1);
    checkOutput("snap at wrap", a_snap, 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, CMD_NOP, 3'd0, 3'd0);
    checkOutput("frame_start one cycle", 64'(a_frame_start), 64'd0);

    // Preload ones, then CLEAR_ALL at pos 5 with a FLIP presented mid-sweep
    repeat (64) applyStimulus(1'b1, 1'b1, 1'b0, CMD_NOP, 3'd0, 3'd0);
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, CMD_NOP, 3'd0, 3'd0);
    checkOutput("pos before clear", 64'(a_pos), 64'd5);
    applyStimulus(1'b1, 1'b1, 1'b1, CMD_CLEAR_ALL, 3'd0, 3'd0);
    rdyLow = 0; fsCount = 0; fdCount = 0;
    for (int k = 0; k < 80; k++) begin
      if (!a_cmd_ready) rdyLow++;
      if (a_frame_start) fsCount++;
      if (a_fill_done) fdCount++;
      if (k == 20) checkOutput("ready mid-sweep", 64'(a_cmd_ready), 64'd0);
      applyStimulus(1'b0, 1'b1, (k == 20), CMD_FLIP, 3'd0, 3'd0);
    end
    checkOutput("ready low cycles", 64'(rdyLow), 64'd64);
    checkOutput("fill_done pulses", 64'(fdCount), 64'd1);
    checkOutput("frame_start in sweep", 64'(fsCount), 64'd1);
    checkOutput("pos after clear", 64'(a_pos), 64'd6);
    spinA(64);
    checkOutput("board cleared", a_snap, 64'd0);

    // Two RANDOM_FILL sweeps from a fresh SEED follow one continuous LFSR sequence
    a_reset = 1'b0;
    tick();
    a_reset = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, CMD_RANDOM_FILL, 3'd0, 3'd0);
    waitFillA("fill A1 done");
    checkOutput("random fill 1", a_snap, randBits[63:0]);
    checkOutput("pos after fill", 64'(a_pos), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, CMD_RANDOM_FILL, 3'd0, 3'd0);
    waitFillA("fill A2 done");
    checkOutput("random fill 2", a_snap, randBits[127:64]);

    // 6x5 board: top corner edit and pos wrap 29 -> 0
    applyStimulusB(1'b0, 1'b0, 1'b1, CMD_FLIP, 3'd5, 3'd4);
    spinB(29);
    checkOutput("B pos 29", 64'(b_pos), 64'd29);
    checkOutput("B no frame yet", 64'(b_frame_start), 64'd0);
    spinB(1);
    checkOutput("B pos wrap", 64'(b_pos), 64'd0);
    checkOutput("B frame_start", 64'(b_frame_start), 64'd1);
    checkOutput("B corner cell", 64'(b_snap), 64'h2000_0000);

    // Out-of-range cursor is accepted, ignored, and still rotates
    checkOutput("B ready for oor", 64'(b_cmd_ready), 64'd1);
    b_cell_in = b_cell_out;
    applyStimulusB(1'b1, b_cell_out, 1'b1, CMD_FLIP, 3'd7, 3'd0);
    checkOutput("B oor rotates", 64'(b_pos), 64'd1);
    spinB(30);
    checkOutput("B oor unchanged", 64'(b_snap), 64'h2000_0000);

    // Reset in the middle of a sweep
    applyStimulusB(1'b0, 1'b0, 1'b1, CMD_RANDOM_FILL, 3'd0, 3'd0);
    repeat (12) tick();
    checkOutput("B busy in sweep", 64'(b_cmd_ready), 64'd0);
    b_reset = 1'b0;
    #1;
    checkOutput("B reset pos", 64'(b_pos), 64'd0);
    checkOutput("B reset snap", 64'(b_snap), 64'd0);
    checkOutput("B reset cell_out", 64'(b_cell_out), 64'd0);
    tick();
    b_reset = 1'b1;
    #1;
    checkOutput("B ready after reset", 64'(b_cmd_ready), 64'd1);
    fdCount = 0;
    for (int k = 0; k < 40; k++) begin
      if (b_fill_done) fdCount++;
      tick();
    end
    checkOutput("B no fill_done", 64'(fdCount), 64'd0);
    applyStimulusB(1'b0, 1'b0, 1'b1, CMD_RANDOM_FILL, 3'd0, 3'd0);
    waitFillB("fill B done");
    checkOutput("B lfsr reseeded", 64'(b_snap), 64'(randBits[29:0]));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
